// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: MULT/MULTU/DIV/DIVU with fixed latency, MTHI/MTLO in one cycle.
// Results are computed at issue and parked in pend_* until the latency counter expires.
module mult_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             state_dbg
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   b_nz, a_mag, b_mag;
    logic [WIDTH-1:0]   mag_q, mag_r, div_q, div_r, divu_q, divu_r;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Arithmetic datapath, evaluated from the operands present on the issue edge
    always_comb begin
        a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
        b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
        a_zx   = {{WIDTH{1'b0}}, a};
        b_zx   = {{WIDTH{1'b0}}, b};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;

        // Divisor forced to 1 when zero so the dividers never see x; that case is overridden below
        b_nz   = (b != '0) ? b : ONE;
        a_mag  = a[WIDTH-1] ? -a : a;
        b_mag  = b_nz[WIDTH-1] ? -b_nz : b_nz;
        mag_q  = a_mag / b_mag;
        mag_r  = a_mag % b_mag;
        div_q  = (a[WIDTH-1] ^ b_nz[WIDTH-1]) ? -mag_q : mag_q;
        div_r  = a[WIDTH-1] ? -mag_r : mag_r;
        divu_q = a / b_nz;
        divu_r = a % b_nz;

        res_hi = '0;
        res_lo = '0;
        case (md_op)
            OP_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            OP_DIV: begin
                if (b == '0) begin
                    res_hi = a;
                    res_lo = ALL_ONES;
                end else if (a == MOST_NEG && b == ALL_ONES) begin
                    res_hi = '0;
                    res_lo = a;
                end else begin
                    res_hi = div_r;
                    res_lo = div_q;
                end
            end
            OP_DIVU: begin
                if (b == '0) begin
                    res_hi = a;
                    res_lo = ALL_ONES;
                end else begin
                    res_hi = divu_r;
                    res_lo = divu_q;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Any start seen while BUSY is dropped: the hazard unit is expected to stall it
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = MUL_LOAD;
                            state_d   = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = DIV_LOAD;
                            state_d   = S_BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: begin
                        end
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_BUSY);
        state_dbg = (state_q == S_BUSY);
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed scenarios plus random ops checked against an arithmetic model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mult_div_unit;

    localparam int W       = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   md_op;
    logic [W-1:0] a, b;
    logic         busy;
    logic [W-1:0] hi, lo;
    logic         state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_hi, m_lo;

    mult_div_unit #(.WIDTH(W), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Architectural model: updates m_hi/m_lo and reports how long busy should stay high
    function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] ra, input logic [W-1:0] rb,
                                   output int lat);
        int sa, sb, sq, sr;
        longint p;
        longint unsigned ua, ub, pu;
        logic [63:0] pv;
        sa = ra;
        sb = rb;
        lat = 0;
        case (op)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                pv = p;
                m_hi = pv[63:32];
                m_lo = pv[31:0];
                lat = MUL_LAT;
            end
            3'd1: begin
                ua = ra;
                ub = rb;
                pu = ua * ub;
                pv = pu;
                m_hi = pv[63:32];
                m_lo = pv[31:0];
                lat = MUL_LAT;
            end
            3'd2: begin
                if (sb == 0) begin
                    m_hi = ra;
                    m_lo = '1;
                end else if (sa == 32'sh8000_0000 && sb == -1) begin
                    m_hi = '0;
                    m_lo = ra;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    m_hi = sr;
                    m_lo = sq;
                end
                lat = DIV_LAT;
            end
            3'd3: begin
                if (rb == 0) begin
                    m_hi = ra;
                    m_lo = '1;
                end else begin
                    m_hi = ra % rb;
                    m_lo = ra / rb;
                end
                lat = DIV_LAT;
            end
            3'd4: m_hi = ra;
            3'd5: m_lo = ra;
            default: begin
            end
        endcase
    endfunction

    function automatic int predict(input logic [2:0] op, input logic [W-1:0] ra, input logic [W-1:0] rb);
        int lat;
        ref_op(op, ra, rb, lat);
        exp_q.push_back({m_hi, m_lo});
        return lat;
    endfunction

    // Issues one op at the current falling edge and measures busy width and final hi/lo
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] ra, input logic [W-1:0] rb,
                          output int cyc, output logic early, output logic [W-1:0] ohi,
                          output logic [W-1:0] olo);
        logic [W-1:0] old_hi, old_lo;
        old_hi = hi;
        old_lo = lo;
        start = 1'b1;
        md_op = op;
        a = ra;
        b = rb;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cyc = 0;
        early = 1'b0;
        while (busy && cyc < 100) begin
            if (hi !== old_hi || lo !== old_lo) early = 1'b1;
            cyc++;
            @(negedge clk);
        end
        ohi = hi;
        olo = lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        md_op = 3'd7;
        a = '0;
        b = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_async: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++;
        if (hi !== '0) begin n_err++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_cmp++;
        if (lo !== '0) begin n_err++; $display("FAIL reset_lo: got %h expected 0", lo); end
        n_cmp++;
        if (state_dbg !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b expected 0", state_dbg); end
    endtask

    task automatic test_directed_ops();
        logic [2:0]   ops[4]  = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [W-1:0] as[4]   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0000_0007};
        logic [W-1:0] bs[4]   = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000};
        logic [2*W-1:0] lit[4] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFE_0000_0001,
                                   64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0007_FFFF_FFFF};
        int lat, cyc;
        logic early;
        logic [W-1:0] ohi, olo;
        logic [2*W-1:0] e;
        for (int i = 0; i < 4; i++) begin
            lat = predict(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], cyc, early, ohi, olo);
            e = exp_q.pop_front();
            n_cmp++;
            if (e !== lit[i]) begin n_err++; $display("FAIL directed_model_%0d: got %h expected %h", i, e, lit[i]); end
            n_cmp++;
            if (cyc !== lat) begin n_err++; $display("FAIL directed_busy_%0d: got %0d expected %0d", i, cyc, lat); end
            n_cmp++;
            if (early !== 1'b0) begin n_err++; $display("FAIL directed_early_%0d: got %b expected 0", i, early); end
            n_cmp++;
            if ({ohi, olo} !== lit[i]) begin n_err++; $display("FAIL directed_hilo_%0d: got %h expected %h", i, {ohi, olo}, lit[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, cyc;
        logic saw_five;
        logic [2*W-1:0] e;
        lat = predict(3'd2, 32'd100, 32'd7);
        start = 1'b1;
        md_op = 3'd2;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        cyc = busy ? 1 : 0;
        md_op = 3'd5;
        a = 32'd5;
        @(negedge clk);
        start = 1'b0;
        saw_five = 1'b0;
        while (busy && cyc < 100) begin
            if (lo === 32'd5) saw_five = 1'b1;
            cyc++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== lat) begin n_err++; $display("FAIL busy_ignore_latency: got %0d expected %0d", cyc, lat); end
        n_cmp++;
        if (saw_five !== 1'b0) begin n_err++; $display("FAIL busy_ignore_mtlo: got %b expected 0", saw_five); end
        n_cmp++;
        if ({hi, lo} !== e) begin n_err++; $display("FAIL busy_ignore_result: got %h expected %h", {hi, lo}, e); end
    endtask

    task automatic test_mthi_mtlo();
        int lat;
        logic [2*W-1:0] e;
        lat = predict(3'd4, 32'h1234_5678, '0);
        start = 1'b1;
        md_op = 3'd4;
        a = 32'h1234_5678;
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (hi !== e[63:32] || busy !== 1'b0) begin
            n_err++; $display("FAIL mthi: got hi=%h busy=%b expected hi=%h busy=0", hi, busy, e[63:32]);
        end
        lat = predict(3'd5, 32'd9, '0);
        md_op = 3'd5;
        a = 32'd9;
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({hi, lo} !== e || busy !== 1'b0) begin
            n_err++; $display("FAIL mtlo: got %h busy=%b expected %h busy=0", {hi, lo}, busy, e);
        end
    endtask

    task automatic test_async_reset();
        int lat, cyc;
        logic early;
        logic [W-1:0] ohi, olo;
        logic [2*W-1:0] e;
        start = 1'b1;
        md_op = 3'd0;
        a = 32'd3;
        b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || state_dbg !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got busy=%b hi=%h lo=%h st=%b expected all 0", busy, hi, lo, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        exp_q.delete();
        @(negedge clk);
        lat = predict(3'd0, 32'hFFFF_FFFB, 32'd7);
        run_op(3'd0, 32'hFFFF_FFFB, 32'd7, cyc, early, ohi, olo);
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== lat) begin n_err++; $display("FAIL post_reset_busy: got %0d expected %0d", cyc, lat); end
        n_cmp++;
        if ({ohi, olo} !== e) begin n_err++; $display("FAIL post_reset_mult: got %h expected %h", {ohi, olo}, e); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [W-1:0] ra, rb;
        int lat, cyc, sel;
        logic early;
        logic [W-1:0] ohi, olo;
        logic [2*W-1:0] e;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 20));
            lat = predict(op, ra, rb);
            run_op(op, ra, rb, cyc, early, ohi, olo);
            e = exp_q.pop_front();
            n_cmp++;
            if (cyc !== lat) begin n_err++; $display("FAIL rand_busy op=%0d: got %0d expected %0d", op, cyc, lat); end
            n_cmp++;
            if (early !== 1'b0) begin n_err++; $display("FAIL rand_early op=%0d: got %b expected 0", op, early); end
            n_cmp++;
            if ({ohi, olo} !== e) begin
                n_err++; $display("FAIL rand_hilo op=%0d a=%h b=%h: got %h expected %h", op, ra, rb, {ohi, olo}, e);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed_ops();
        test_start_while_busy();
        test_mthi_mtlo();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
